// File: rtl/muldiv_pkg.sv
// Shared types for the execute-side multiply/divide sequencer.
// Optional single-cycle multiply: MULDIV_FASTMUL_EN.
package muldiv_pkg;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } md_state_e;

  function automatic logic md_is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/e_divstep.sv
// One restoring-divide step: shift in a dividend bit, trial-subtract.
// Combinational; the sequencer registers the results.
module e_divstep #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_data_rem,
  input  logic              i_data_bit,
  input  logic [DATA_W-1:0] i_data_div,
  output logic [DATA_W-1:0] o_data_rem,
  output logic              o_con_qbit
);

  logic [DATA_W:0] shifted;

  assign shifted    = {i_data_rem, i_data_bit};
  assign o_con_qbit = (shifted >= {1'b0, i_data_div});
  // remainder stays below the divisor, so DATA_W bits always suffice
  assign o_data_rem = o_con_qbit
                    ? DATA_W'(shifted - {1'b0, i_data_div})
                    : DATA_W'(shifted);

endmodule

// File: rtl/e_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// MULDIV_FASTMUL_EN: multiply done with one native 64-bit product.
module e_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_con_start,
  input  logic [1:0]        i_con_op,
  input  logic [DATA_W-1:0] i_data_rs,
  input  logic [DATA_W-1:0] i_data_rt,
  input  logic              i_con_hiloread,
  input  logic              i_con_mthi,
  input  logic              i_con_mtlo,
  input  logic              i_con_flush,
  output logic [DATA_W-1:0] o_data_hi,
  output logic [DATA_W-1:0] o_data_lo,
  output logic              o_con_busy,
  output logic              o_con_stall,
  output logic              o_con_done,
  output logic              o_con_divzero
);

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_in;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] opa_q, opb_q;
  logic [DATA_W-1:0] acc_hi_q, acc_lo_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              sa_q, sb_q, dz_q;

  logic              in_div, in_sgn;
  logic              rs_neg, rt_neg, rt_zero;
  logic [DATA_W-1:0] rs_mag, rt_mag;
  logic              is_div, last_iter;

  logic [DATA_W-1:0]   div_rem;
  logic                div_qbit;
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  assign op_in   = md_op_e'(i_con_op);
  assign in_div  = md_is_div(op_in);
  assign in_sgn  = md_is_signed(op_in);
  assign rs_neg  = in_sgn & i_data_rs[DATA_W-1];
  assign rt_neg  = in_sgn & i_data_rt[DATA_W-1];
  assign rs_mag  = rs_neg ? -i_data_rs : i_data_rs;
  assign rt_mag  = rt_neg ? -i_data_rt : i_data_rt;
  assign rt_zero = (i_data_rt == '0);
  assign is_div  = md_is_div(op_q);

`ifdef MULDIV_FASTMUL_EN
  logic [2*DATA_W-1:0] fast_prod;

  assign fast_prod = (2*DATA_W)'(opa_q) * (2*DATA_W)'(opb_q);
  assign last_iter = ~is_div
                   | (cnt_q == CNT_W'(MD_ITER - 1));
`else
  logic [DATA_W:0] mul_sum;

  // shift-add: {acc_hi,acc_lo} holds partial product and multiplier
  assign mul_sum = {1'b0, acc_hi_q}
                 + (acc_lo_q[0] ? {1'b0, opa_q} : '0);
  assign last_iter = (cnt_q == CNT_W'(MD_ITER - 1));
`endif

  e_divstep #(
    .DATA_W (DATA_W)
  ) u_divstep (
    .i_data_rem (acc_hi_q),
    .i_data_bit (acc_lo_q[DATA_W-1]),
    .i_data_div (opb_q),
    .o_data_rem (div_rem),
    .o_con_qbit (div_qbit)
  );

  // sign flags are only set for signed ops
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;
  assign quo_fix  = (sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = sa_q ? -acc_hi_q : acc_hi_q;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_con_start) begin
          state_d = (in_div && rt_zero) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (last_iter) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (i_con_flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      op_q     <= MD_MULT;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_con_start) begin
            op_q     <= op_in;
            cnt_q    <= '0;
            opa_q    <= rs_mag;
            opb_q    <= rt_mag;
            acc_hi_q <= '0;
            acc_lo_q <= in_div ? rs_mag : rt_mag;
            sa_q     <= rs_neg;
            sb_q     <= rt_neg;
            dz_q     <= in_div & rt_zero;
          end
        end
        ST_CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (is_div) begin
            acc_hi_q <= div_rem;
            acc_lo_q <= {acc_lo_q[DATA_W-2:0], div_qbit};
          end else begin
`ifdef MULDIV_FASTMUL_EN
            {acc_hi_q, acc_lo_q} <= fast_prod;
`else
            acc_hi_q <= mul_sum[DATA_W:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[DATA_W-1:1]};
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == ST_FIX) begin
      if (!i_con_flush) begin
        if (is_div) begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end else begin
          hi_q <= prod_fix[2*DATA_W-1:DATA_W];
          lo_q <= prod_fix[DATA_W-1:0];
        end
      end
    end else if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
      if (i_con_mthi) hi_q <= i_data_rs;
      if (i_con_mtlo) lo_q <= i_data_rs;
    end
  end

  assign o_data_hi     = hi_q;
  assign o_data_lo     = lo_q;
  assign o_con_busy    = (state_q != ST_IDLE);
  assign o_con_done    = (state_q == ST_DONE);
  assign o_con_divzero = (state_q == ST_DONE) & dz_q;
  assign o_con_stall   = (i_con_start | i_con_hiloread)
                       & ((state_q == ST_CALC) | (state_q == ST_FIX));

endmodule
